// File: rtl/input_ctrl.sv
// Button conditioning for top_vga: 2-flop sync + debounce per button, left/right
// conflict resolution, and a frame-aligned one-frame jump request, all gated by game_active.
module input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_jump,
  input  logic btn_down,
  input  logic frame_tick,
  input  logic game_active,
  output logic stepleft,
  output logic stepright,
  output logic stepjump,
  output logic buttondown
);

  localparam int NUM_CH   = 4;
  localparam int CH_LEFT  = 0;
  localparam int CH_RIGHT = 1;
  localparam int CH_JUMP  = 2;
  localparam int CH_DOWN  = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_CH-1:0]            raw, s1, s2, db;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt;
  logic                         db_jump_q, jump_pend, jump_edge;

  assign raw = {btn_down, btn_jump, btn_right, btn_left};

  // Only s1 may go metastable; everything downstream sees s2.
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      always_ff @(posedge clk) begin
        if (!rst) begin
          s1[i]  <= 1'b0;
          s2[i]  <= 1'b0;
          db[i]  <= 1'b0;
          cnt[i] <= '0;
        end else begin
          s1[i] <= raw[i];
          s2[i] <= s1[i];
          if (s2[i] == db[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == CNT_MAX) begin
            db[i]  <= s2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  endgenerate

  assign jump_edge = db[CH_JUMP] & ~db_jump_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      db_jump_q  <= 1'b0;
      jump_pend  <= 1'b0;
      stepleft   <= 1'b0;
      stepright  <= 1'b0;
      stepjump   <= 1'b0;
      buttondown <= 1'b0;
    end else begin
      db_jump_q  <= db[CH_JUMP];
      stepleft   <= game_active & db[CH_LEFT] & ~db[CH_RIGHT];
      stepright  <= game_active & db[CH_RIGHT] & ~db[CH_LEFT];
      buttondown <= game_active & db[CH_DOWN];
      // An edge coincident with the tick is carried into the next frame, not dropped.
      if (!game_active) begin
        jump_pend <= 1'b0;
        stepjump  <= 1'b0;
      end else if (frame_tick) begin
        stepjump  <= jump_pend;
        jump_pend <= jump_edge;
      end else if (jump_edge) begin
        jump_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_input_ctrl.sv
// Directed bench for input_ctrl with DEBOUNCE_CYCLES=8 and a frame_tick every 100 cycles.
module tb_input_ctrl;

  localparam int DB = 8;
  localparam int FRAME = 100;

  logic clk = 1'b0;
  logic rst, btn_left, btn_right, btn_jump, btn_down, frame_tick, game_active;
  logic stepleft, stepright, stepjump, buttondown;

  int total = 0;
  int bad = 0;
  int fc = 0;

  input_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst(rst),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump), .btn_down(btn_down),
    .frame_tick(frame_tick), .game_active(game_active),
    .stepleft(stepleft), .stepright(stepright), .stepjump(stepjump), .buttondown(buttondown)
  );

  always #5 clk = ~clk;

  // One clock: returns at the next falling edge with frame_tick set up for the coming rising edge.
  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      fc = (fc + 1) % FRAME;
      frame_tick = (fc == 0);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance until the next rising edge carries frame_tick; returns 1 if found in budget.
  task automatic wait_tick(output logic found);
    found = 1'b0;
    for (int k = 0; k < 3 * FRAME && !found; k++) begin
      if (frame_tick) found = 1'b1;
      else cyc();
    end
  endtask

  // Button held: one 100-cycle stepjump pulse from the next tick, then nothing while held.
  task automatic jump_pulse_check(input string tag);
    logic found, ok;
    wait_tick(found);
    chk({tag, "_tick_found"}, found, 1'b1);
    chk({tag, "_pre_tick"}, stepjump, 1'b0);
    cyc();
    chk({tag, "_rise"}, stepjump, 1'b1);
    ok = 1'b1;
    for (int k = 0; k < FRAME - 1; k++) begin
      cyc();
      if (stepjump !== 1'b1) ok = 1'b0;
    end
    chk({tag, "_held_frame"}, ok, 1'b1);
    cyc();
    chk({tag, "_fall"}, stepjump, 1'b0);
    ok = 1'b1;
    for (int k = 0; k < FRAME + 10; k++) begin
      cyc();
      if (stepjump !== 1'b0) ok = 1'b0;
    end
    chk({tag, "_no_repeat"}, ok, 1'b1);
  endtask

  initial begin
    logic ok;
    frame_tick = 1'b0;
    // Reset with inputs high; right stays low so the left output is not cancelled by conflict.
    rst = 1'b0; btn_left = 1'b1; btn_right = 1'b0; btn_jump = 1'b1; btn_down = 1'b1;
    game_active = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if ({stepleft, stepright, stepjump, buttondown} !== 4'b0) ok = 1'b0;
    end
    chk("reset_outputs", ok, 1'b1);
    chk("reset_cnt", dut.cnt[0], 0);
    rst = 1'b1;
    cyc(DB + 2);
    chk("reset_left_edge9", stepleft, 1'b0);
    chk("reset_down_edge9", buttondown, 1'b0);
    cyc();
    chk("reset_left_edge10", stepleft, 1'b1);
    chk("reset_down_edge10", buttondown, 1'b1);

    // Release everything and let any jump pulse from the reset test run out.
    btn_left = 1'b0; btn_jump = 1'b0; btn_down = 1'b0;
    cyc(2 * FRAME + 20);
    chk("idle_left", stepleft, 1'b0);
    chk("idle_down", buttondown, 1'b0);
    chk("idle_jump", stepjump, 1'b0);

    // Glitch rejection: 7-cycle pulse never flips the debounced state.
    btn_left = 1'b1;
    cyc(DB - 1);
    btn_left = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (stepleft !== 1'b0) ok = 1'b0;
    end
    chk("glitch_left_low", ok, 1'b1);
    chk("glitch_cnt_zero", dut.cnt[0], 0);

    // 8-cycle pulse: rises at edge 10, falls at edge 18 (release edge 8 + 10).
    btn_left = 1'b1;
    cyc(DB);
    btn_left = 1'b0;
    cyc(2);
    chk("pulse8_edge9", stepleft, 1'b0);
    cyc();
    chk("pulse8_edge10", stepleft, 1'b1);
    cyc(7);
    chk("pulse8_edge17", stepleft, 1'b1);
    cyc();
    chk("pulse8_edge18", stepleft, 1'b0);
    cyc(10);

    // Conflict: both held cancels both outputs.
    btn_left = 1'b1;
    cyc(DB + 4);
    chk("conf_left_only", stepleft, 1'b1);
    btn_right = 1'b1;
    cyc(DB + 2);
    chk("conf_left_edge9", stepleft, 1'b1);
    cyc();
    chk("conf_both_left", stepleft, 1'b0);
    chk("conf_both_right", stepright, 1'b0);
    btn_left = 1'b0;
    cyc(DB + 3);
    chk("conf_right_after", stepright, 1'b1);
    chk("conf_left_after", stepleft, 1'b0);
    btn_right = 1'b0;
    cyc(DB + 4);
    chk("conf_right_rel", stepright, 1'b0);

    // Jump framing: press mid-frame, hold, then a second press after release.
    while (fc != 40) cyc();
    btn_jump = 1'b1;
    jump_pulse_check("jump1");
    btn_jump = 1'b0;
    cyc(20);
    btn_jump = 1'b1;
    jump_pulse_check("jump2");
    btn_jump = 1'b0;
    cyc(20);

    // Edge k after press sees a tick when (fc+k)%100==0: press at fc=90 puts jump_edge on the tick at edge 10.
    while (fc != 90) cyc();
    btn_jump = 1'b1;
    cyc(DB + 3);
    chk("coinc_pend_set", dut.jump_pend, 1'b1);
    chk("coinc_stepjump_0", stepjump, 1'b0);
    cyc(FRAME - 1);
    chk("coinc_frame_low", stepjump, 1'b0);
    cyc();
    chk("coinc_next_tick", stepjump, 1'b1);

    // Game inactive while stepjump high and left held.
    btn_left = 1'b1;
    cyc(DB + 3);
    chk("inact_left_pre", stepleft, 1'b1);
    chk("inact_jump_pre", stepjump, 1'b1);
    game_active = 1'b0;
    cyc();
    chk("inact_jump", stepjump, 1'b0);
    chk("inact_left", stepleft, 1'b0);
    chk("inact_pend", dut.jump_pend, 1'b0);
    cyc(5);
    game_active = 1'b1;
    cyc();
    chk("resume_left", stepleft, 1'b1);
    ok = 1'b1;
    for (int k = 0; k < FRAME + 10; k++) begin
      cyc();
      if (stepjump !== 1'b0) ok = 1'b0;
    end
    chk("resume_no_jump", ok, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_ctrl.md
# input_ctrl

Conditions the raw board buttons before they reach `top_vga`. It synchronises and debounces the four push-buttons and resolves left/right conflicts. It converts a jump press into a request aligned to `frame_tick`, which lasts exactly one frame, and gates all outputs with the game-active state. Its outputs drive `stepleft`, `stepright`, `stepjump` and `buttondown` of `top_vga`.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 650000: number of consecutive `clk` cycles a synchronised input must differ from its debounced state before the state flips (10 ms at 65 MHz). Legal range ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: width of each debounce counter.

Ports:
- `clk`, input, 1: pixel clock, the same domain as `top_vga`. One clock; reset is synchronous and active-low.
- `rst`, input, 1: synchronous reset, active-low. Reset is applied when `rst`==0 at a rising edge of `clk`.
- `btn_left`, input, 1: raw, asynchronous left button (active-high).
- `btn_right`, input, 1: raw right button.
- `btn_jump`, input, 1: raw jump button.
- `btn_down`, input, 1: raw down button.
- `frame_tick`, input, 1: one-cycle pulse per frame, generated in the `clk` domain.
- `game_active`, input, 1: 1 while the game FSM is in the play state.
- `stepleft`, output, 1: debounced left level.
- `stepright`, output, 1: debounced right level.
- `stepjump`, output, 1: jump request, high for one full frame.
- `buttondown`, output, 1: debounced down level.

## Operation

- **Synchroniser.** Each `btn_*` passes through a 2-flop synchroniser (`s1`, then `s2`). Both flops reset to 0.
- **Debounce, per channel.** Each channel has a state `db` and a counter `cnt` of width `CNT_W`.
  - If `s2`==`db`: `cnt` <= 0.
  - Otherwise, if `cnt`==`DEBOUNCE_CYCLES-1`: `db` <= `s2` and `cnt` <= 0.
  - Otherwise: `cnt` <= `cnt`+1.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles restarts the count and never changes `db`.
  - `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so it cannot wrap.
- **Left/right resolution.** The outputs are registered:
  - `stepleft` <= `game_active` & `db_left` & ~`db_right`.
  - `stepright` <= `game_active` & `db_right` & ~`db_left`.
  - If both buttons are held, both outputs are 0.
- **Down.** `buttondown` <= `game_active` & `db_down`.
- **Jump.**
  - The rising edge of `db_jump` is detected using the registered previous value `db_jump_q`. That edge sets `jump_pend`.
  - On `frame_tick`: `stepjump` <= `jump_pend` & `game_active`, and `jump_pend` <= `jump_edge`. A new edge in the same cycle as `frame_tick` is therefore not lost.
  - Between ticks, `stepjump` holds its value. Multiple edges within one frame merge into a single request.
  - Holding jump does not auto-repeat. A new press, i.e. release then press with both debounced, is required.
- **Inactive game.** While `game_active`==0:
  - `jump_pend` is cleared each cycle.
  - `stepjump` is cleared on the next cycle, without waiting for `frame_tick`.
  - The debouncers keep running, so the `db` states remain valid when play resumes.

## Timing

- **Reset.** On reset, all flops and outputs go to 0: `s1`, `s2`, `db`, `db_jump_q`, `cnt`, `jump_pend`, `stepleft`, `stepright`, `stepjump`, `buttondown`. Reset applied mid-count discards the partial count.
- **Level latency.** Let edge 0 be the first rising edge at which the raw input is sampled at its new, stable value. Then:
  - `s1` changes at edge 0.
  - `s2` changes at edge 1.
  - `db` changes at edge 1+`DEBOUNCE_CYCLES`.
  - `stepleft`, `stepright` and `buttondown` change at edge 2+`DEBOUNCE_CYCLES`.
  - Release follows the same latency.
- **Jump latency.**
  - `jump_pend` rises at edge 2+`DEBOUNCE_CYCLES`.
  - `stepjump` rises at the first `frame_tick` edge after that, and falls at the next `frame_tick` edge.
- **`game_active` timing.** `game_active` affects the level outputs with 1 cycle of latency.
- **Async inputs.** Raw inputs may change at any time. Only `s1` may go metastable.

## Test plan

Run with `DEBOUNCE_CYCLES`=8 and `frame_tick` every 100 cycles.

1. **Reset.** Drive all inputs high with `rst`=0 for 5 cycles, then set `rst`=1. Required: all outputs are 0 during reset, and `stepleft` rises exactly at edge 10 after release (2+8).
2. **Glitch rejection.** Pulse `btn_left` high for 7 cycles, then hold it low for 20 cycles. Required: `stepleft` stays 0 and `cnt` returns to 0. A following 8-cycle pulse sets `stepleft`=1 at edge 10.
3. **Conflict.** Hold left until `stepleft`=1, then also press right. Required: 10 cycles after the right press, both `stepleft` and `stepright` are 0. After left is released and debounced, `stepright`=1.
4. **Jump framing.** Press and hold jump, with the debounced edge landing mid-frame. Required: `stepjump`=1 from the next `frame_tick` for exactly 100 cycles, then 0 while the button is still held. Release, wait 20 cycles, and press again; another single 100-cycle pulse follows.
5. **Jump and tick coincident.** Arrange for `jump_edge` to occur in the same cycle as `frame_tick`, with `jump_pend`=0. Required: `stepjump` stays 0 for that frame and rises at the following tick.
6. **Game inactive.** Set `game_active`=0 while `stepjump`=1 and left is held. Required: `stepjump` and `stepleft` are 0 one cycle later, and no jump is pending. Set `game_active`=1. Required: `stepleft`=1 one cycle later, and `stepjump` stays 0.
